// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: divides enable-generator ticks into pattern steps and
// drives an LED bank in OFF, BLINK, CHASE or BOUNCE mode.
module led_pattern_sequencer #(
    parameter int LED_COUNT = 8,
    parameter int DIV_W     = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 tick_enable,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_W-1:0]     ticks_per_step,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 step_strobe,
    output logic                 dir_up
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    localparam logic [LED_COUNT-1:0] FIRST_LED = {{(LED_COUNT-1){1'b0}}, 1'b1};

    mode_t                 active_mode;
    mode_t                 req_mode;
    logic [DIV_W-1:0]      tcnt;
    logic [DIV_W-1:0]      term;
    logic [LED_COUNT-1:0]  shl;
    logic [LED_COUNT-1:0]  shr;
    logic [LED_COUNT-1:0]  rotl;

    assign req_mode = mode_t'(mode);

    // A ticks_per_step of 0 behaves exactly like 1: every tick is a step.
    assign term = (ticks_per_step == '0) ? '0 : ticks_per_step - 1'b1;

    assign shl  = {led_out[LED_COUNT-2:0], 1'b0};
    assign shr  = {1'b0, led_out[LED_COUNT-1:1]};
    assign rotl = {led_out[LED_COUNT-2:0], led_out[LED_COUNT-1]};

    // Mode reload takes priority over tick counting, so a tick landing on a
    // mode change is dropped and the new pattern always starts from tcnt=0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            active_mode <= MODE_OFF;
            tcnt        <= '0;
            led_out     <= '0;
            step_strobe <= 1'b0;
            dir_up      <= 1'b1;
        end else begin
            step_strobe <= 1'b0;
            if (req_mode != active_mode) begin
                active_mode <= req_mode;
                tcnt        <= '0;
                dir_up      <= 1'b1;
                case (req_mode)
                    MODE_OFF:   led_out <= '0;
                    MODE_BLINK: led_out <= '1;
                    default:    led_out <= FIRST_LED;
                endcase
            end else if (enable && tick_enable) begin
                if (tcnt >= term) begin
                    tcnt        <= '0;
                    step_strobe <= 1'b1;
                    case (active_mode)
                        MODE_OFF:    led_out <= '0;
                        MODE_BLINK:  led_out <= ~led_out;
                        MODE_CHASE:  led_out <= rotl;
                        MODE_BOUNCE: begin
                            // Direction flips on the same edge that lands on an end LED.
                            if (dir_up) begin
                                led_out <= shl;
                                if (shl[LED_COUNT-1]) dir_up <= 1'b0;
                            end else begin
                                led_out <= shr;
                                if (shr[0]) dir_up <= 1'b1;
                            end
                        end
                        default:     led_out <= '0;
                    endcase
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer: an 8-LED and a 4-LED instance
// share stimulus; the 4-LED instance is checked only for the BOUNCE sequence.
module tb_led_pattern_sequencer;

    logic       sys_clk;
    logic       sys_rst;
    logic       tick_enable;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] ticks_per_step;

    logic [7:0] led8;
    logic       strobe8;
    logic       dir8;
    logic [3:0] led4;
    logic       strobe4;
    logic       dir4;

    int vectors;
    int miscompares;

    led_pattern_sequencer #(.LED_COUNT(8), .DIV_W(4)) dut8 (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .tick_enable    (tick_enable),
        .enable         (enable),
        .mode           (mode),
        .ticks_per_step (ticks_per_step),
        .led_out        (led8),
        .step_strobe    (strobe8),
        .dir_up         (dir8)
    );

    led_pattern_sequencer #(.LED_COUNT(4), .DIV_W(4)) dut4 (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .tick_enable    (tick_enable),
        .enable         (enable),
        .mode           (mode),
        .ticks_per_step (ticks_per_step),
        .led_out        (led4),
        .step_strobe    (strobe4),
        .dir_up         (dir4)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One clock cycle with tick_enable at the given level; outputs are settled on return.
    task automatic applyStimulus(input logic te);
        tick_enable = te;
        @(posedge sys_clk);
        #1;
        tick_enable = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] exp8;
        logic [3:0] bnc_led [8];
        logic       bnc_dir [8];

        bnc_led = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
        bnc_dir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        vectors        = 0;
        miscompares    = 0;
        sys_rst        = 1'b1;
        tick_enable    = 1'b0;
        enable         = 1'b0;
        mode           = 2'b00;
        ticks_per_step = 4'd1;

        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("reset_led8", 32'(led8), 32'h00);
        checkOutput("reset_strobe", 32'(strobe8), 32'h0);
        checkOutput("reset_dir", 32'(dir8), 32'h1);
        checkOutput("reset_led4", 32'(led4), 32'h0);

        $display("[TB] CHASE, ticks_per_step=1");
        sys_rst = 1'b0;
        mode    = 2'b10;
        enable  = 1'b1;
        applyStimulus(1'b0);
        checkOutput("chase_load", 32'(led8), 32'h01);
        checkOutput("chase_load_strobe", 32'(strobe8), 32'h0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1);
            exp8 = 8'(1 << (i % 8));
            checkOutput("chase_led", 32'(led8), 32'(exp8));
            checkOutput("chase_strobe", 32'(strobe8), 32'h1);
        end
        applyStimulus(1'b0);
        checkOutput("chase_idle_strobe", 32'(strobe8), 32'h0);
        checkOutput("chase_idle_led", 32'(led8), 32'h04);

        $display("[TB] freeze");
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1);
            checkOutput("freeze_led", 32'(led8), 32'h04);
            checkOutput("freeze_strobe", 32'(strobe8), 32'h0);
        end
        enable = 1'b1;
        applyStimulus(1'b1);
        checkOutput("unfreeze_led", 32'(led8), 32'h08);
        checkOutput("unfreeze_strobe", 32'(strobe8), 32'h1);

        $display("[TB] mode switch with simultaneous tick");
        applyStimulus(1'b1);
        checkOutput("pre_switch_led", 32'(led8), 32'h10);
        ticks_per_step = 4'd2;
        applyStimulus(1'b1);
        checkOutput("pre_switch_count_led", 32'(led8), 32'h10);
        checkOutput("pre_switch_count_strobe", 32'(strobe8), 32'h0);
        mode = 2'b11;
        applyStimulus(1'b1);
        checkOutput("switch_led", 32'(led8), 32'h01);
        checkOutput("switch_dir", 32'(dir8), 32'h1);
        checkOutput("switch_strobe", 32'(strobe8), 32'h0);
        applyStimulus(1'b1);
        checkOutput("switch_tcnt_led", 32'(led8), 32'h01);
        checkOutput("switch_tcnt_strobe", 32'(strobe8), 32'h0);
        applyStimulus(1'b1);
        checkOutput("switch_step_led", 32'(led8), 32'h02);
        checkOutput("switch_step_strobe", 32'(strobe8), 32'h1);

        $display("[TB] OFF still strobes");
        mode           = 2'b00;
        ticks_per_step = 4'd0;
        applyStimulus(1'b0);
        checkOutput("off_load", 32'(led8), 32'h00);
        applyStimulus(1'b1);
        checkOutput("off_step_led", 32'(led8), 32'h00);
        checkOutput("off_step_strobe", 32'(strobe8), 32'h1);

        $display("[TB] BOUNCE, 4 LEDs, ticks_per_step=0");
        mode = 2'b11;
        applyStimulus(1'b0);
        checkOutput("bounce_load_led", 32'(led4), 32'h1);
        checkOutput("bounce_load_dir", 32'(dir4), 32'h1);
        checkOutput("bounce_load_strobe", 32'(strobe4), 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1);
            checkOutput("bounce_led", 32'(led4), 32'(bnc_led[i]));
            checkOutput("bounce_dir", 32'(dir4), 32'(bnc_dir[i]));
        end

        $display("[TB] BLINK, ticks_per_step=3");
        mode           = 2'b01;
        ticks_per_step = 4'd3;
        applyStimulus(1'b0);
        checkOutput("blink_load", 32'(led8), 32'hFF);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1);
            exp8 = (((i / 3) % 2) == 1) ? 8'h00 : 8'hFF;
            checkOutput("blink_led", 32'(led8), 32'(exp8));
            checkOutput("blink_strobe", 32'(strobe8), (i % 3 == 0) ? 32'h1 : 32'h0);
        end

        $display("[TB] lower ticks_per_step mid-count");
        applyStimulus(1'b1);
        checkOutput("lower_pre_led", 32'(led8), 32'h00);
        ticks_per_step = 4'd1;
        applyStimulus(1'b1);
        checkOutput("lower_step_led", 32'(led8), 32'hFF);
        checkOutput("lower_step_strobe", 32'(strobe8), 32'h1);
        ticks_per_step = 4'd3;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("tcnt2_led", 32'(led8), 32'hFF);
        checkOutput("tcnt2_strobe", 32'(strobe8), 32'h0);

        $display("[TB] reset mid-run");
        sys_rst = 1'b1;
        applyStimulus(1'b1);
        checkOutput("midrst_led", 32'(led8), 32'h00);
        checkOutput("midrst_strobe", 32'(strobe8), 32'h0);
        checkOutput("midrst_dir", 32'(dir8), 32'h1);
        sys_rst = 1'b0;
        applyStimulus(1'b0);
        checkOutput("midrst_reload", 32'(led8), 32'hFF);
        checkOutput("midrst_reload_strobe", 32'(strobe8), 32'h0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("midrst_count_led", 32'(led8), 32'hFF);
        applyStimulus(1'b1);
        checkOutput("midrst_step_led", 32'(led8), 32'h00);
        checkOutput("midrst_step_strobe", 32'(strobe8), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
